cc_line_deserializer: RTL and testbench



---
 rtl/cc_deser_pkg.sv | 16 +
 rtl/cc_ofs_queue.sv | 70 +++++++
 rtl/cc_line_deserializer.sv | 113 +++++++++++
 tb/tb_cc_line_deserializer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_deser_pkg.sv
// Shared types and sizes for the miss-path read-return line assembler.
// Holds beat/line/offset widths, the assembler state type and the fill-FIFO entry type.
package cc_deser_pkg;

    localparam int unsigned BEATS   = 8;
    localparam int unsigned BEAT_W  = 64;
    localparam int unsigned LINE_W  = 512;
    localparam int unsigned OFS_W   = 6;
    localparam int unsigned ENTRY_W = 518;
    localparam int unsigned WIDX_W  = 3;

    typedef enum logic {S_COLLECT, S_FLUSH} deser_state_t;

    typedef logic [ENTRY_W-1:0] fill_entry_t;

endpackage

// File: rtl/cc_ofs_queue.sv
// Small synchronous FIFO of byte offsets for outstanding line reads.
// Ports: clk, rst_n (sync, active-low), push/push_ofs (enqueue, ignored when full),
//        pop (dequeue, ignored when empty), head (oldest offset), full, empty.
// DEPTH must be a power of two, >= 2.
module cc_ofs_queue
    import cc_deser_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [OFS_W-1:0] push_ofs,
    input  logic             pop,
    output logic [OFS_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [OFS_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_ofs;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full    <= (count_d == CNT_W'(DEPTH));
            empty   <= (count_d == '0);
        end
    end

endmodule

// File: rtl/cc_line_deserializer.sv
// Assembles eight critical-word-first 64-bit read beats into a 512-bit line and
// writes {byte offset, line} into the fill FIFO.
// Ports: clk, rst_n (sync, active-low);
//        arvalid_i/araddr_ofs_i/arready_o : read-request offset capture;
//        rdata_i/rlast_i/rvalid_i/rready_o : read-return beats;
//        fifo_full_i/fifo_wren_o/fifo_wdata_o : fill FIFO write side.
// Optional macro CC_DESER_RLAST_CHK_EN adds sticky rlast_err_o (beat framing check).
module cc_line_deserializer
    import cc_deser_pkg::*;
#(
    parameter int unsigned OFS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arvalid_i,
    input  logic [OFS_W-1:0]    araddr_ofs_i,
    output logic                arready_o,
    input  logic [BEAT_W-1:0]   rdata_i,
    input  logic                rlast_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    input  logic                fifo_full_i,
    output logic                fifo_wren_o,
    output logic [ENTRY_W-1:0]  fifo_wdata_o
`ifdef CC_DESER_RLAST_CHK_EN
    ,
    output logic                rlast_err_o
`endif
);

    deser_state_t                   state_q;
    deser_state_t                   state_d;
    logic [WIDX_W-1:0]              cnt_q;
    logic [BEATS-1:0][BEAT_W-1:0]   words_q;
    logic [WIDX_W-1:0]              wr_idx;
    logic                           beat_acc;
    logic [OFS_W-1:0]               ofs_head;
    logic                           ofs_full;
    logic                           ofs_empty;

    cc_ofs_queue #(
        .DEPTH (OFS_DEPTH)
    ) u_ofs_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (arvalid_i),
        .push_ofs (araddr_ofs_i),
        .pop      (fifo_wren_o),
        .head     (ofs_head),
        .full     (ofs_full),
        .empty    (ofs_empty)
    );

    assign arready_o = ~ofs_full;
    assign beat_acc  = rvalid_i & rready_o;
    // Wrapped word position: start at the requested word, 3-bit truncating add.
    assign wr_idx    = ofs_head[5:3] + cnt_q;

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        rready_o     = 1'b0;
        fifo_wren_o  = 1'b0;
        fifo_wdata_o = '0;
        case (state_q)
            S_COLLECT: begin
                rready_o = ~ofs_empty;
                if (rvalid_i && !ofs_empty && (cnt_q == WIDX_W'(BEATS - 1))) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                fifo_wren_o  = ~fifo_full_i;
                fifo_wdata_o = {ofs_head, words_q};
                if (!fifo_full_i) begin
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    // State, beat counter and line register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            if (beat_acc) begin
                cnt_q <= cnt_q + WIDX_W'(1);
                // Word 0 sits in the MSBs, so word w is packed element 7-w (= ~w).
                words_q[~wr_idx] <= rdata_i;
            end
        end
    end

`ifdef CC_DESER_RLAST_CHK_EN
    // Sticky flag: rlast_i must be high exactly on the eighth beat of a line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rlast_err_o <= 1'b0;
        end else if (beat_acc && (rlast_i != (cnt_q == WIDX_W'(BEATS - 1)))) begin
            rlast_err_o <= 1'b1;
        end
    end
`else
    logic rlast_unused;
    assign rlast_unused = rlast_i;
`endif

endmodule

// File: tb/tb_cc_line_deserializer.sv
// Directed bench for cc_line_deserializer: wrapped beat placement, fill-FIFO
// back-pressure, offset-queue full/order behaviour and mid-burst reset.
module tb_cc_line_deserializer;
    import cc_deser_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               arvalid_i;
    logic [OFS_W-1:0]   araddr_ofs_i;
    logic               arready_o;
    logic [BEAT_W-1:0]  rdata_i;
    logic               rlast_i;
    logic               rvalid_i;
    logic               rready_o;
    logic               fifo_full_i;
    logic               fifo_wren_o;
    logic [ENTRY_W-1:0] fifo_wdata_o;
`ifdef CC_DESER_RLAST_CHK_EN
    logic               rlast_err_o;
    logic               exp_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] d [8];
    logic [63:0] b [8];
    logic [63:0] c [8];
    logic [63:0] e [8];
    logic [63:0] f [8];

    always #5 clk = ~clk;

    cc_line_deserializer #(
        .OFS_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arvalid_i    (arvalid_i),
        .araddr_ofs_i (araddr_ofs_i),
        .arready_o    (arready_o),
        .rdata_i      (rdata_i),
        .rlast_i      (rlast_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wren_o  (fifo_wren_o),
        .fifo_wdata_o (fifo_wdata_o)
`ifdef CC_DESER_RLAST_CHK_EN
        ,
        .rlast_err_o  (rlast_err_o)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [ENTRY_W-1:0] obs,
                         input logic [ENTRY_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mk(output logic [63:0] arr [8], input logic [31:0] base);
        for (int k = 0; k < 8; k++) arr[k] = {base, 32'(k)};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, ENTRY_W'(arready_o), ENTRY_W'(1));
        check({tag, "_rready"},  ENTRY_W'(rready_o),  ENTRY_W'(0));
        check({tag, "_wren"},    ENTRY_W'(fifo_wren_o), ENTRY_W'(0));
        check({tag, "_wdata"},   fifo_wdata_o, '0);
    endtask

    task automatic request(input logic [5:0] ofs);
        arvalid_i    = 1'b1;
        araddr_ofs_i = ofs;
        tick();
        arvalid_i    = 1'b0;
    endtask

    // Sends beats 0..n-1; rlast_i is raised on beat last_k; max_gap inserts random idle cycles.
    task automatic send_beats(input logic [63:0] arr [8], input int n, input int last_k,
                              input int max_gap, input string tag);
        for (int k = 0; k < n; k++) begin
            int g;
            int w;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            rvalid_i = 1'b0;
            repeat (g) tick();
            rvalid_i = 1'b1;
            rdata_i  = arr[k];
            rlast_i  = (k == last_k);
            w = 0;
            while (!rready_o && w < 20) begin
                tick();
                w++;
            end
            check({tag, "_rready"}, ENTRY_W'(rready_o), ENTRY_W'(1));
            tick();
            rvalid_i = 1'b0;
            rlast_i  = 1'b0;
`ifdef CC_DESER_RLAST_CHK_EN
            exp_err = exp_err | ((k == last_k) != (k == 7));
            check({tag, "_rlast_err"}, ENTRY_W'(rlast_err_o), ENTRY_W'(exp_err));
`endif
        end
    endtask

    // Called right after the edge that accepted beat 7.
    task automatic expect_write(input logic [5:0] ofs, input logic [511:0] line,
                                input int full_cycles, input string tag);
        fifo_full_i = (full_cycles > 0);
        for (int i = 0; i < full_cycles; i++) begin
            #1;
            check({tag, "_hold_wren"},   ENTRY_W'(fifo_wren_o), ENTRY_W'(0));
            check({tag, "_hold_rready"}, ENTRY_W'(rready_o),    ENTRY_W'(0));
            tick();
        end
        fifo_full_i = 1'b0;
        #1;
        check({tag, "_wren"},  ENTRY_W'(fifo_wren_o), ENTRY_W'(1));
        check({tag, "_wdata"}, fifo_wdata_o, {ofs, line});
        tick();
        check({tag, "_wren_off"}, ENTRY_W'(fifo_wren_o), ENTRY_W'(0));
    endtask

    initial begin
        rst_n        = 1'b0;
        arvalid_i    = 1'b0;
        araddr_ofs_i = '0;
        rdata_i      = '0;
        rlast_i      = 1'b0;
        rvalid_i     = 1'b0;
        fifo_full_i  = 1'b0;
`ifdef CC_DESER_RLAST_CHK_EN
        exp_err      = 1'b0;
`endif
        mk(d, 32'hD0D0_0000);
        mk(b, 32'hB0B0_0000);
        mk(c, 32'hC0C0_0000);
        mk(e, 32'hE0E0_0000);
        mk(f, 32'hF0F0_0000);

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
`ifdef CC_DESER_RLAST_CHK_EN
        check("reset_rlast_err", ENTRY_W'(rlast_err_o), ENTRY_W'(0));
`endif
        rst_n = 1'b1;
        tick();

        // Beat offered with empty queue is not accepted
        rvalid_i = 1'b1;
        #1;
        check("empty_q_rready", ENTRY_W'(rready_o), ENTRY_W'(0));
        tick();
        rvalid_i = 1'b0;

        // Offset 0x00, back-to-back beats
        request(6'h00);
        send_beats(d, 8, 7, 0, "t1");
        expect_write(6'h00, {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]}, 0, "t1");

        // Offset 0x28: first beat lands in word 5
        request(6'h28);
        send_beats(b, 8, 7, 0, "t2");
        expect_write(6'h28, {b[3], b[4], b[5], b[6], b[7], b[0], b[1], b[2]}, 0, "t2");

        // Offset 0x18 with random gaps and 5 cycles of fill-FIFO back-pressure
        request(6'h18);
        send_beats(c, 8, 7, 3, "t3");
        expect_write(6'h18, {c[5], c[6], c[7], c[0], c[1], c[2], c[3], c[4]}, 5, "t3");

        // Fill the offset queue, then a rejected push at full
        request(6'h00);
        request(6'h08);
        request(6'h38);
        check("q3_arready", ENTRY_W'(arready_o), ENTRY_W'(1));
        request(6'h10);
        check("qfull_arready", ENTRY_W'(arready_o), ENTRY_W'(0));
        arvalid_i    = 1'b1;
        araddr_ofs_i = 6'h20;
        tick();
        check("qfull_hold_arready", ENTRY_W'(arready_o), ENTRY_W'(0));
        arvalid_i = 1'b0;

        send_beats(e, 8, 7, 0, "q0");
        expect_write(6'h00, {e[0], e[1], e[2], e[3], e[4], e[5], e[6], e[7]}, 0, "q0");
        check("q_after_write_arready", ENTRY_W'(arready_o), ENTRY_W'(1));
        send_beats(e, 8, 7, 0, "q1");
        expect_write(6'h08, {e[7], e[0], e[1], e[2], e[3], e[4], e[5], e[6]}, 0, "q1");
        send_beats(e, 8, 7, 0, "q2");
        expect_write(6'h38, {e[1], e[2], e[3], e[4], e[5], e[6], e[7], e[0]}, 0, "q2");
        send_beats(e, 8, 7, 0, "q3");
        expect_write(6'h10, {e[6], e[7], e[0], e[1], e[2], e[3], e[4], e[5]}, 0, "q3");

        // Queue drained; the rejected 0x20 request must not be present
        rvalid_i = 1'b1;
        #1;
        check("drained_rready", ENTRY_W'(rready_o), ENTRY_W'(0));
        tick();
        rvalid_i = 1'b0;

        // Reset after 3 beats discards partial line and queued offsets
        request(6'h08);
        request(6'h30);
        send_beats(b, 3, 7, 0, "rst_part");
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
`ifdef CC_DESER_RLAST_CHK_EN
        exp_err = 1'b0;
`endif
        rst_n = 1'b1;
        tick();
        check("midrst_q_empty_rready", ENTRY_W'(rready_o), ENTRY_W'(0));
        request(6'h00);
        send_beats(f, 8, 7, 0, "t5");
        expect_write(6'h00, {f[0], f[1], f[2], f[3], f[4], f[5], f[6], f[7]}, 0, "t5");

`ifdef CC_DESER_RLAST_CHK_EN
        // rlast_i on beat 4: sticky error, line still written
        request(6'h00);
        send_beats(d, 8, 4, 0, "t6");
        expect_write(6'h00, {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]}, 0, "t6");
        tick();
        check("t6_err_sticky", ENTRY_W'(rlast_err_o), ENTRY_W'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
